// File: rtl/msrv32_load_unit.sv
// -----------------------------------------------------------------------------
// msrv32_load_unit
//
// Load-data alignment and extension stage for the MS-RISCV32 write-back path.
// The raw 32-bit word returned by the AHB data bus is narrowed to the byte,
// halfword or word addressed by the load. The selection is then zero- or
// sign-extended to 32 bits and registered for the register-file write-back mux.
//
// Ports:
//   ms_riscv32_mp_clk_in    in   1  core clock, rising-edge active
//   ms_riscv32_mp_rst_in    in   1  asynchronous active-high reset
//   ahb_resp_in             in   1  0 = bus data valid (OKAY), 1 = not valid
//   ms_risc32_mp_dmdata_in  in  32  raw word read from data memory
//   iadder_out_1_to_0_in    in   2  low two bits of the load effective address
//   load_unsigned_in        in   1  1 = zero-extend, 0 = sign-extend
//   load_size_in            in   2  00 byte, 01 halfword, 1x word
//   lu_output_out           out 32  aligned/extended load result (registered)
//   lu_valid_out            out  1  pulses when lu_output_out was just updated
// -----------------------------------------------------------------------------
module msrv32_load_unit (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        ahb_resp_in,
   input  logic [31:0] ms_risc32_mp_dmdata_in,
   input  logic [1:0]  iadder_out_1_to_0_in,
   input  logic        load_unsigned_in,
   input  logic [1:0]  load_size_in,
   output logic [31:0] lu_output_out,
   output logic        lu_valid_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] result;

   logic [31:0] lu_output_d;
   logic [31:0] lu_output_q;
   logic        lu_valid_d;
   logic        lu_valid_q;

   // Byte lane chosen directly by the two address bits.
   always_comb begin
      byte_sel = ms_risc32_mp_dmdata_in[7:0];
      case (iadder_out_1_to_0_in)
         2'b00:   byte_sel = ms_risc32_mp_dmdata_in[7:0];
         2'b01:   byte_sel = ms_risc32_mp_dmdata_in[15:8];
         2'b10:   byte_sel = ms_risc32_mp_dmdata_in[23:16];
         default: byte_sel = ms_risc32_mp_dmdata_in[31:24];
      endcase
   end

   // Halfword lane uses only address bit 1; a misaligned bit 0 is ignored
   // here, trapping is handled elsewhere in the core.
   always_comb begin
      half_sel = iadder_out_1_to_0_in[1] ? ms_risc32_mp_dmdata_in[31:16]
                                         : ms_risc32_mp_dmdata_in[15:0];
   end

   // Extension of the selected lane; word loads pass through untouched.
   always_comb begin
      result = ms_risc32_mp_dmdata_in;
      case (load_size_in)
         2'b00:   result = {{24{~load_unsigned_in & byte_sel[7]}}, byte_sel};
         2'b01:   result = {{16{~load_unsigned_in & half_sel[15]}}, half_sel};
         default: result = ms_risc32_mp_dmdata_in;
      endcase
   end

   // A bus response other than OKAY leaves the previous result in place and
   // suppresses the valid pulse.
   always_comb begin
      lu_output_d = lu_output_q;
      lu_valid_d  = 1'b0;
      if (!ahb_resp_in) begin
         lu_output_d = result;
         lu_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         lu_output_q <= 32'h0000_0000;
         lu_valid_q  <= 1'b0;
      end else begin
         lu_output_q <= lu_output_d;
         lu_valid_q  <= lu_valid_d;
      end
   end

   assign lu_output_out = lu_output_q;
   assign lu_valid_out  = lu_valid_q;

endmodule

// File: tb/tb_msrv32_load_unit.sv
// -----------------------------------------------------------------------------
// tb_msrv32_load_unit
//
// Directed-vector bench for msrv32_load_unit. Each driven cycle pushes its
// hand-computed expected {valid, data} into a queue; a separate monitor pops
// and compares one entry per clock edge while entries are pending.
// -----------------------------------------------------------------------------
module tb_msrv32_load_unit;

   logic        clk;
   logic        rst;
   logic        ahb_resp;
   logic [31:0] dmdata;
   logic [1:0]  addr;
   logic        uns;
   logic [1:0]  size;
   logic [31:0] lu_output;
   logic        lu_valid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          id;
      logic        valid;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      logic        resp;
      logic [31:0] data;
      logic [1:0]  addr;
      logic        uns;
      logic [1:0]  size;
      logic [31:0] exp;
   } vec_t;

   msrv32_load_unit dut (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_in   (rst),
      .ahb_resp_in            (ahb_resp),
      .ms_risc32_mp_dmdata_in (dmdata),
      .iadder_out_1_to_0_in   (addr),
      .load_unsigned_in       (uns),
      .load_size_in           (size),
      .lu_output_out          (lu_output),
      .lu_valid_out           (lu_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected values are hand-computed; for resp = 1 entries the expected
   // data is the last captured value.
   vec_t vecs [0:15] = '{
      '{1'b0, 32'hA5A5A5A5, 2'b01, 1'b0, 2'b00, 32'hFFFF_FFA5},
      '{1'b1, 32'h12345678, 2'b00, 1'b0, 2'b10, 32'hFFFF_FFA5},
      '{1'b1, 32'h12345678, 2'b00, 1'b0, 2'b10, 32'hFFFF_FFA5},
      '{1'b1, 32'h12345678, 2'b00, 1'b0, 2'b10, 32'hFFFF_FFA5},
      '{1'b0, 32'h12345678, 2'b00, 1'b0, 2'b10, 32'h1234_5678},
      '{1'b0, 32'h34567A43, 2'b10, 1'b1, 2'b00, 32'h0000_0056},
      '{1'b0, 32'h34567A43, 2'b00, 1'b1, 2'b00, 32'h0000_0043},
      '{1'b0, 32'hA5A5A5A5, 2'b11, 1'b0, 2'b01, 32'hFFFF_A5A5},
      '{1'b0, 32'h0234567A, 2'b00, 1'b0, 2'b01, 32'h0000_567A},
      '{1'b0, 32'h0234567A, 2'b10, 1'b0, 2'b01, 32'h0000_0234},
      '{1'b0, 32'hA5A5A5A5, 2'b11, 1'b0, 2'b11, 32'hA5A5_A5A5},
      '{1'b0, 32'hA5A5A5A5, 2'b00, 1'b1, 2'b10, 32'hA5A5_A5A5},
      '{1'b0, 32'h80000000, 2'b11, 1'b0, 2'b00, 32'hFFFF_FF80},
      '{1'b0, 32'h80011234, 2'b10, 1'b1, 2'b01, 32'h0000_8001},
      '{1'b0, 32'hA5A5A5A5, 2'b01, 1'b1, 2'b00, 32'h0000_00A5},
      '{1'b0, 32'h0000007F, 2'b00, 1'b0, 2'b00, 32'h0000_007F}
   };

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_checks++;
               if (lu_valid !== e.valid) begin
                  n_fail++;
                  $display("FAIL valid[%0d]: got %b, expected %b", e.id, lu_valid, e.valid);
               end
               n_checks++;
               if (lu_output !== e.data) begin
                  n_fail++;
                  $display("FAIL data[%0d]: got %08h, expected %08h", e.id, lu_output, e.data);
               end
               $display("txn %0d: valid=%b data=%08h (expected %b %08h)",
                        e.id, lu_valid, lu_output, e.valid, e.data);
            end else if (lu_valid !== 1'b0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_valid: got %b, expected 0", lu_valid);
            end
         end
      end
   end

   task automatic drive(input vec_t v, input int id);
      exp_t e;
      @(posedge clk);
      #2;
      ahb_resp = v.resp;
      dmdata   = v.data;
      addr     = v.addr;
      uns      = v.uns;
      size     = v.size;
      e.id     = id;
      e.valid  = ~v.resp;
      e.data   = v.exp;
      exp_q.push_back(e);
   endtask

   task automatic idle_and_drain();
      int budget;
      @(posedge clk);
      #2;
      ahb_resp = 1'b1;
      dmdata   = 32'hDEAD_BEEF;
      budget   = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         #3;
         budget++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries pending, expected 0", exp_q.size());
      end
   endtask

   initial begin
      rst      = 1'b1;
      ahb_resp = 1'b1;
      dmdata   = 32'h0;
      addr     = 2'b00;
      uns      = 1'b0;
      size     = 2'b00;

      repeat (2) @(posedge clk);
      #3;
      n_checks++;
      if (lu_output !== 32'h0 || lu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %08h/%b, expected 00000000/0", lu_output, lu_valid);
      end
      $display("txn reset: data=%08h valid=%b", lu_output, lu_valid);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) drive(vecs[i], i);
      idle_and_drain();

      // Output holds 000000A5; assert reset between edges.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (lu_output !== 32'h0 || lu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %08h/%b, expected 00000000/0", lu_output, lu_valid);
      end
      $display("txn async_reset: data=%08h valid=%b", lu_output, lu_valid);

      // Inputs presented while in reset must not be captured.
      ahb_resp = 1'b0;
      dmdata   = 32'hFFFF_FFFF;
      size     = 2'b10;
      @(posedge clk);
      #1;
      n_checks++;
      if (lu_output !== 32'h0 || lu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: got %08h/%b, expected 00000000/0", lu_output, lu_valid);
      end
      $display("txn reset_hold: data=%08h valid=%b", lu_output, lu_valid);
      ahb_resp = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      drive(vecs[15], 15);
      idle_and_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/msrv32_load_unit.md
Name:
msrv32_load_unit

Overview:
- Load-data alignment and extension unit for the MS-RISCV32 core's write-back path.
- Takes the 32-bit word returned by the AHB data bus and selects the byte, halfword or word addressed by the load.
- Zero- or sign-extends the selection to 32 bits and registers it for the register-file write-back mux.
- Sits between the data-memory interface and the write-back stage.

Parameters:
- None. Data width is fixed at 32 bits; the register reset value is fixed at 32'h0000_0000.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
- ahb_resp_in  input  1  AHB response: 0 = data valid (OKAY), 1 = not valid (error/wait).
- ms_risc32_mp_dmdata_in  input  32  raw word read from data memory.
- iadder_out_1_to_0_in  input  2  low two bits of the load effective address.
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
- load_size_in  input  2  00 = byte, 01 = halfword, 10 = word, 11 = word.
- lu_output_out  output  32  aligned and extended load result (registered).
- lu_valid_out  output  1  high for one cycle when lu_output_out was updated by the preceding edge.

Behaviour:
- Reset (asynchronous, active-high, while ms_riscv32_mp_rst_in = 1):
  - lu_output_out = 32'h0000_0000.
  - lu_valid_out = 0.
  - Reset takes effect immediately and overrides any capture in progress.
- Combinational result computation:
  - Byte (load_size_in = 00): offset 00 selects dmdata[7:0], 01 selects [15:8], 10 selects [23:16], 11 selects [31:24].
  - Halfword (load_size_in = 01): iadder_out_1_to_0_in[1] = 0 selects dmdata[15:0]; 1 selects [31:16]. Bit 0 is ignored (misaligned accesses are not trapped here).
  - Word (load_size_in = 10 or 11): dmdata[31:0] unchanged. Address bits and load_unsigned_in are ignored.
  - Extension: load_unsigned_in = 1 fills the upper bits with 0. load_unsigned_in = 0 replicates the selected byte's bit 7 or the selected halfword's bit 15.
- Register update on the rising clock edge:
  - ahb_resp_in = 0: lu_output_out <= computed result; lu_valid_out <= 1.
  - ahb_resp_in = 1: lu_output_out holds its previous value; lu_valid_out <= 0.
- Latency: exactly one clock cycle from valid inputs to the output. No handshake beyond ahb_resp_in; a new load may be presented every cycle.
- Input changes between edges have no effect on the outputs.
- Reset released mid-stream: the first capture happens at the first rising edge after deassertion.
- No X or Z is ever driven on any output.

Test Plan:
- Assert reset mid-run with lu_output_out nonzero -> lu_output_out = 32'h0000_0000 and lu_valid_out = 0 immediately, with no clock edge required.
- Byte load, signed: dmdata = 32'hA5A5A5A5, addr = 01, unsigned = 0, size = 00, resp = 0 -> after one edge lu_output_out = 32'hFFFF_FFA5, lu_valid_out = 1.
- Byte load, unsigned: dmdata = 32'h34567A43, addr = 10, unsigned = 1, size = 00 -> 32'h0000_0056. Then addr = 00 -> 32'h0000_0043.
- Halfword loads:
  - dmdata = 32'hA5A5A5A5, addr = 11, signed, size = 01 -> 32'hFFFF_A5A5.
  - dmdata = 32'h0234567A, addr = 00, signed, size = 01 -> 32'h0000_567A.
  - Same data, addr = 10, signed -> 32'h0000_0234.
- Word loads: dmdata = 32'hA5A5A5A5, size = 11, addr = 11 -> 32'hA5A5_A5A5. Size = 10 with unsigned = 1 -> 32'hA5A5_A5A5.
- Bus not ready: after capturing 32'hFFFF_FFA5, set resp = 1 and dmdata = 32'h1234_5678 for 3 cycles -> lu_output_out stays 32'hFFFF_FFA5 and lu_valid_out = 0. Then resp = 0 with word size -> 32'h1234_5678 one edge later.
